rename_regfile_ckpt: RTL and testbench
======================================

# rename_regfile_ckpt

Parametrised architectural register file with rename-tag (Q) table and branch checkpoints, sitting between the dispatcher and the ROB. It supplies source operands (value V plus pending ROB tag Q) with same-cycle bypass of dispatch allocation and ROB commit. It also keeps up to NUM_CKPT snapshots of the Q table, so a mispredicted branch restores its own snapshot instead of clearing every tag. A full flush path is retained for exceptions and for global rollback.

## Interface
Parameters:
- NUM_REGS, 32: architectural registers; register 0 hard-wired to zero.
- DATA_W, 32: value width.
- TAG_W, 4: ROB tag width; tag 0 means "no pending producer".
- NUM_SRC, 2: source read ports.
- NUM_CKPT, 4: checkpoint slots; power of two, at least 2.

Ports:
- clk in 1: clock.
- rst_n in 1: asynchronous, active-low reset.
- rdy in 1: global enable; low freezes all state.
- rs_i in NUM_SRC*RW: source register indices, with RW = $clog2(NUM_REGS).
- v_o out NUM_SRC*DATA_W: source values.
- q_o out NUM_SRC*TAG_W: source pending tags.
- alloc_valid_i in 1, alloc_rd_i in RW, alloc_tag_i in TAG_W: dispatcher renames alloc_rd_i to alloc_tag_i.
- commit_valid_i in 1, commit_rd_i in RW, commit_tag_i in TAG_W, commit_data_i in DATA_W: ROB retirement.
- ckpt_req_i in 1: take a snapshot.
- ckpt_release_i in 1: free the oldest snapshot; its branch resolved correctly.
- restore_valid_i in 1, restore_id_i in CW: mispredict recovery, with CW = $clog2(NUM_CKPT).
- flush_i in 1: clear all Q entries and free all checkpoints.
- ckpt_id_o out CW: slot assigned to the next ckpt_req_i.
- ckpt_full_o out 1, ckpt_count_o out CW+1: checkpoint occupancy.

## Operation
- Reset (rst_n low, asynchronous):
  - All V, all Q, head, tail and count go to 0.
  - Outputs are therefore ckpt_id_o=0, ckpt_full_o=0, ckpt_count_o=0.
- Read path (combinational):
  - rs=0 always returns V=0, Q=0.
  - Q result: alloc_tag_i if alloc is effective and alloc_rd_i==rs. Otherwise the stored Q, or that slot's snapshot entry when a restore is effective.
  - The Q result is then forced to 0 if commit_valid_i, commit_rd_i==rs and commit_tag_i equals that Q result.
  - V: commit_data_i if commit_valid_i and commit_rd_i==rs; otherwise the stored V.
- Per-cycle priority: flush_i > restore_valid_i > {alloc, ckpt_req}.
  - Alloc is effective only if alloc_valid_i is high, alloc_rd_i≠0, and there is no flush or restore.
- Commit, applied in every enabled cycle including flush and restore cycles:
  - V[rd] is written, unless rd=0.
  - Q[rd] is cleared only if its post-alloc/restore value equals commit_tag_i.
  - The same conditional clear is applied to entry rd of every live snapshot, so a restore never resurrects a retired tag.
- Checkpoint FIFO:
  - Head = oldest slot, tail = ckpt_id_o.
  - ckpt_req_i with not full: snap[tail] ← next-state Q, which includes this cycle's alloc and commit clear. Then tail++ and count++.
  - ckpt_req_i while full is ignored. The dispatcher must stall on ckpt_full_o.
  - ckpt_release_i with count>0: head++ and count--. Release while empty is ignored.
  - Request and release in the same cycle leave count unchanged.
- Restore, for a live restore_id_i:
  - Q ← snap[id] with the commit clear applied.
  - tail ← id, and count ← (id − head) mod NUM_CKPT, which frees slot id and all younger slots.
  - Alloc, ckpt_req and release are ignored that cycle.
  - A non-live id makes the restore ignored entirely, while commit still applies.
- Flush: all Q ← 0, head=tail=count=0. Commit still writes V.

## Timing
- Reads are zero-latency; all updates take effect at posedge clk when rdy=1.
- A value committed in cycle n is visible unbypassed from cycle n+1.
- A snapshot taken in cycle n can be restored from cycle n+1.
- ckpt_full_o and ckpt_count_o reflect registered state only; there is no same-cycle lookahead.
- Pointers wrap modulo NUM_CKPT.
- rdy=0 holds everything and ignores all inputs. Read outputs stay combinational.
- Reset asserted mid-operation discards all snapshots immediately.

## Structure
- Shared package holds:
  - REG_POS_W, TAG_W, DATA_W.
  - ZERO_TAG, ZERO_REG, ZERO_WORD.
  - CKPT_ID_W.
- Sub-module ckpt_fifo_ctrl owns head, tail and count; full, live-id and restore-count logic; and pointer wrap.
- The top level owns the V and Q arrays, the snapshot array and the bypass muxes.

## Test plan
- Bypass:
  - Stimulus: alloc x5→tag3 while reading x5.
  - Required: q=3. Next cycle, commit x5 tag3 data 0xAB while reading x5 gives v=0xAB and q=0.
- Stale commit:
  - Stimulus: alloc x7→2, then x7→4, then commit x7 tag2 data 9.
  - Required: V[7]=9 and Q[7] stays 4.
- Checkpoint and restore:
  - Stimulus: alloc x1→1, ckpt (id0), alloc x1→5, ckpt (id1), alloc x2→6, restore id0.
  - Required: Q[1]=1, Q[2]=0, count=0, ckpt_id_o=0.
- Retired tag in snapshot:
  - Stimulus: alloc x3→2, ckpt, commit x3 tag2, restore id0.
  - Required: Q[3]=0.
- Full and wrap:
  - Stimulus: four ckpt requests.
  - Required: full=1. A fifth request is ignored. Release plus request in one cycle keeps count=4 with tail wrapped to 1.
- Flush and reset:
  - Stimulus: flush with live checkpoints and a same-cycle commit x4 data 0x11.
  - Required: all Q=0, count=0, V[4]=0x11.
  - Then: rst_n pulsed low asynchronously between edges clears everything before the next edge.

Source files
------------

// File: rtl/rename_regfile_ckpt_pkg.sv
// Shared widths and zero constants for the rename register file and its
// checkpoint FIFO controller.
package rename_regfile_ckpt_pkg;

  localparam int REG_POS_W = 5;
  localparam int TAG_W     = 4;
  localparam int DATA_W    = 32;
  localparam int CKPT_ID_W = 2;

  localparam logic [REG_POS_W-1:0] ZERO_REG  = '0;
  localparam logic [TAG_W-1:0]     ZERO_TAG  = '0;
  localparam logic [DATA_W-1:0]    ZERO_WORD = '0;

endpackage

// File: rtl/rename_regfile_ckpt_fifo_ctrl.sv
// Circular allocation of checkpoint slots: head is the oldest live snapshot,
// tail is the slot the next snapshot goes into.
import rename_regfile_ckpt_pkg::*;

module ckpt_fifo_ctrl #(
  parameter int  NUM_CKPT = 1 << CKPT_ID_W,
  localparam int CW       = $clog2(NUM_CKPT)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          rdy,
  input  logic          flush,
  input  logic          restore_valid,
  input  logic [CW-1:0] restore_id,
  input  logic          req,
  input  logic          rel_req,
  output logic [CW-1:0] tail,
  output logic [CW:0]   count,
  output logic          full,
  output logic          take,
  output logic          restore_eff
);

  logic [CW-1:0] head_reg;
  logic [CW-1:0] tail_reg;
  logic [CW:0]   count_reg;
  logic [CW-1:0] restore_off;
  logic          live;
  logic          ordinary;
  logic          rel;

  // Distance from the oldest slot; natural wrap since NUM_CKPT is a power of two.
  assign restore_off = restore_id - head_reg;
  assign live        = {1'b0, restore_off} < count_reg;
  assign full        = (count_reg == (CW+1)'(NUM_CKPT));

  assign ordinary    = rdy & ~flush & ~restore_valid;
  assign rel         = ordinary & rel_req & (count_reg != '0);
  // A full FIFO still accepts a request when the oldest slot frees up in the same cycle.
  assign take        = ordinary & req & (~full | rel);
  assign restore_eff = rdy & ~flush & restore_valid & live;

  assign tail  = tail_reg;
  assign count = count_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else if (rdy) begin
      if (flush) begin
        head_reg  <= '0;
        tail_reg  <= '0;
        count_reg <= '0;
      end else if (restore_valid) begin
        if (live) begin
          tail_reg  <= restore_id;
          count_reg <= {1'b0, restore_off};
        end
      end else begin
        if (take) tail_reg <= tail_reg + CW'(1);
        if (rel)  head_reg <= head_reg + CW'(1);
        if (take && !rel)      count_reg <= count_reg + (CW+1)'(1);
        else if (rel && !take) count_reg <= count_reg - (CW+1)'(1);
      end
    end
  end

endmodule

// File: rtl/rename_regfile_ckpt.sv
// Architectural register file with rename-tag table, bypassed source reads
// and branch checkpoints of the tag table.
import rename_regfile_ckpt_pkg::*;

module rename_regfile_ckpt #(
  parameter int  NUM_REGS = 1 << REG_POS_W,
  parameter int  DATA_W   = rename_regfile_ckpt_pkg::DATA_W,
  parameter int  TAG_W    = rename_regfile_ckpt_pkg::TAG_W,
  parameter int  NUM_SRC  = 2,
  parameter int  NUM_CKPT = 1 << CKPT_ID_W,
  localparam int RW       = $clog2(NUM_REGS),
  localparam int CW       = $clog2(NUM_CKPT)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      rdy,
  input  logic [NUM_SRC*RW-1:0]     rs_i,
  output logic [NUM_SRC*DATA_W-1:0] v_o,
  output logic [NUM_SRC*TAG_W-1:0]  q_o,
  input  logic                      alloc_valid_i,
  input  logic [RW-1:0]             alloc_rd_i,
  input  logic [TAG_W-1:0]          alloc_tag_i,
  input  logic                      commit_valid_i,
  input  logic [RW-1:0]             commit_rd_i,
  input  logic [TAG_W-1:0]          commit_tag_i,
  input  logic [DATA_W-1:0]         commit_data_i,
  input  logic                      ckpt_req_i,
  input  logic                      ckpt_release_i,
  input  logic                      restore_valid_i,
  input  logic [CW-1:0]             restore_id_i,
  input  logic                      flush_i,
  output logic [CW-1:0]             ckpt_id_o,
  output logic                      ckpt_full_o,
  output logic [CW:0]               ckpt_count_o
);

  logic [DATA_W-1:0] v_reg    [NUM_REGS];
  logic [TAG_W-1:0]  q_reg    [NUM_REGS];
  logic [TAG_W-1:0]  q_base   [NUM_REGS];
  logic [TAG_W-1:0]  q_next   [NUM_REGS];
  logic [TAG_W-1:0]  snap_reg [NUM_CKPT][NUM_REGS];

  logic          commit_eff;
  logic          alloc_eff;
  logic          take;
  logic          restore_eff;
  logic [CW-1:0] tail;

  ckpt_fifo_ctrl #(.NUM_CKPT(NUM_CKPT)) u_fifo (
    .clk          (clk),
    .rst_n        (rst_n),
    .rdy          (rdy),
    .flush        (flush_i),
    .restore_valid(restore_valid_i),
    .restore_id   (restore_id_i),
    .req          (ckpt_req_i),
    .rel_req      (ckpt_release_i),
    .tail         (tail),
    .count        (ckpt_count_o),
    .full         (ckpt_full_o),
    .take         (take),
    .restore_eff  (restore_eff)
  );

  assign ckpt_id_o  = tail;
  assign commit_eff = rdy & commit_valid_i;
  assign alloc_eff  = rdy & alloc_valid_i & (alloc_rd_i != ZERO_REG) & ~flush_i & ~restore_valid_i;

  // Next-state tag table; also the image a same-cycle checkpoint captures.
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      if (flush_i)
        q_base[r] = ZERO_TAG;
      else if (restore_eff)
        q_base[r] = snap_reg[restore_id_i][r];
      else if (alloc_eff && alloc_rd_i == RW'(r))
        q_base[r] = alloc_tag_i;
      else
        q_base[r] = q_reg[r];
      if (r == 0 || (commit_eff && commit_rd_i == RW'(r) && commit_tag_i == q_base[r]))
        q_next[r] = ZERO_TAG;
      else
        q_next[r] = q_base[r];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        v_reg[r] <= ZERO_WORD;
        q_reg[r] <= ZERO_TAG;
      end
    end else if (rdy) begin
      for (int r = 0; r < NUM_REGS; r++) q_reg[r] <= q_next[r];
      if (commit_eff && commit_rd_i != ZERO_REG) v_reg[commit_rd_i] <= commit_data_i;
    end
  end

  // Retired tags are scrubbed from every slot; dead slots are fully rewritten
  // before they become live again, so clearing them too is harmless.
  always_ff @(posedge clk) begin
    if (rdy) begin
      if (commit_eff) begin
        for (int s = 0; s < NUM_CKPT; s++) begin
          if (snap_reg[s][commit_rd_i] == commit_tag_i) snap_reg[s][commit_rd_i] <= ZERO_TAG;
        end
      end
      if (take) begin
        for (int r = 0; r < NUM_REGS; r++) snap_reg[tail][r] <= q_next[r];
      end
    end
  end

  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
    logic [RW-1:0]     rs;
    logic [TAG_W-1:0]  q_pick;
    logic [TAG_W-1:0]  q_res;
    logic [DATA_W-1:0] v_res;

    assign rs = rs_i[gi*RW +: RW];

    always_comb begin
      if (alloc_eff && alloc_rd_i == rs)
        q_pick = alloc_tag_i;
      else if (restore_eff)
        q_pick = snap_reg[restore_id_i][rs];
      else
        q_pick = q_reg[rs];

      if (rs == ZERO_REG || (commit_eff && commit_rd_i == rs && commit_tag_i == q_pick))
        q_res = ZERO_TAG;
      else
        q_res = q_pick;

      if (rs == ZERO_REG)
        v_res = ZERO_WORD;
      else if (commit_eff && commit_rd_i == rs)
        v_res = commit_data_i;
      else
        v_res = v_reg[rs];
    end

    assign q_o[gi*TAG_W +: TAG_W]   = q_res;
    assign v_o[gi*DATA_W +: DATA_W] = v_res;
  end

endmodule

// File: tb/tb_rename_regfile_ckpt.sv
// Directed scenarios plus random traffic against a queue-based model of the
// rename table and its checkpoint list.
module tb_rename_regfile_ckpt;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rdy;
  logic [9:0]  rs;
  logic [63:0] v_o;
  logic [7:0]  q_o;
  logic        alloc_valid;
  logic [4:0]  alloc_rd;
  logic [3:0]  alloc_tag;
  logic        commit_valid;
  logic [4:0]  commit_rd;
  logic [3:0]  commit_tag;
  logic [31:0] commit_data;
  logic        ckpt_req;
  logic        ckpt_release;
  logic        restore_valid;
  logic [1:0]  restore_id;
  logic        flush;
  logic [1:0]  ckpt_id;
  logic        ckpt_full;
  logic [2:0]  ckpt_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rename_regfile_ckpt dut (
    .clk(clk), .rst_n(rst_n), .rdy(rdy), .rs_i(rs), .v_o(v_o), .q_o(q_o),
    .alloc_valid_i(alloc_valid), .alloc_rd_i(alloc_rd), .alloc_tag_i(alloc_tag),
    .commit_valid_i(commit_valid), .commit_rd_i(commit_rd), .commit_tag_i(commit_tag),
    .commit_data_i(commit_data), .ckpt_req_i(ckpt_req), .ckpt_release_i(ckpt_release),
    .restore_valid_i(restore_valid), .restore_id_i(restore_id), .flush_i(flush),
    .ckpt_id_o(ckpt_id), .ckpt_full_o(ckpt_full), .ckpt_count_o(ckpt_count)
  );

  // Reference model: register arrays plus an ordered list of (slot id, table copy).
  typedef logic [3:0] qtab_t [32];
  logic [31:0] m_v [32];
  qtab_t       m_q;
  qtab_t       m_snap [$];
  int          m_ids [$];
  int          m_next;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int r = 0; r < 32; r++) begin
      m_v[r] = '0;
      m_q[r] = '0;
    end
    m_snap.delete();
    m_ids.delete();
    m_next = 0;
  endtask

  function automatic int find_ckpt(int id);
    foreach (m_ids[k]) if (m_ids[k] == id) return k;
    return -1;
  endfunction

  function automatic logic m_alloc_eff();
    return rdy && alloc_valid && alloc_rd != 0 && !flush && !restore_valid;
  endfunction

  function automatic logic [3:0] exp_q(logic [4:0] r);
    logic [3:0] t;
    int k;
    if (r == 0) return 4'd0;
    k = find_ckpt(int'(restore_id));
    if (m_alloc_eff() && alloc_rd == r) t = alloc_tag;
    else if (rdy && !flush && restore_valid && k >= 0) t = m_snap[k][r];
    else t = m_q[r];
    if (rdy && commit_valid && commit_rd == r && commit_tag == t) t = 4'd0;
    return t;
  endfunction

  function automatic logic [31:0] exp_v(logic [4:0] r);
    if (r == 0) return 32'd0;
    if (rdy && commit_valid && commit_rd == r) return commit_data;
    return m_v[r];
  endfunction

  task automatic check_outputs();
    for (int s = 0; s < 2; s++) begin
      logic [4:0] r;
      r = rs[s*5 +: 5];
      check_eq($sformatf("v%0d(x%0d)", s, r), 64'(v_o[s*32 +: 32]), 64'(exp_v(r)));
      check_eq($sformatf("q%0d(x%0d)", s, r), 64'(q_o[s*4 +: 4]), 64'(exp_q(r)));
    end
    check_eq("ckpt_id", 64'(ckpt_id), 64'(m_next));
    check_eq("ckpt_full", 64'(ckpt_full), 64'(m_ids.size() == 4));
    check_eq("ckpt_count", 64'(ckpt_count), 64'(m_ids.size()));
  endtask

  task automatic model_update();
    logic rel, tk, ae;
    int k;
    if (!rdy) return;
    ae = m_alloc_eff();
    if (flush) begin
      for (int r = 0; r < 32; r++) m_q[r] = '0;
      m_snap.delete();
      m_ids.delete();
      m_next = 0;
    end else if (restore_valid) begin
      k = find_ckpt(int'(restore_id));
      if (k >= 0) begin
        m_q = m_snap[k];
        while (m_ids.size() > k) begin
          void'(m_ids.pop_back());
          void'(m_snap.pop_back());
        end
        m_next = int'(restore_id);
      end
    end else if (ae) begin
      m_q[alloc_rd] = alloc_tag;
    end
    if (commit_valid) begin
      if (commit_rd != 0) m_v[commit_rd] = commit_data;
      if (m_q[commit_rd] == commit_tag) m_q[commit_rd] = '0;
      foreach (m_snap[j]) if (m_snap[j][commit_rd] == commit_tag) m_snap[j][commit_rd] = '0;
    end
    if (!flush && !restore_valid) begin
      rel = ckpt_release && m_ids.size() > 0;
      tk  = ckpt_req && (m_ids.size() < 4 || rel);
      if (rel) begin
        void'(m_ids.pop_front());
        void'(m_snap.pop_front());
      end
      if (tk) begin
        m_snap.push_back(m_q);
        m_ids.push_back(m_next);
        m_next = (m_next + 1) % 4;
      end
    end
  endtask

  task automatic idle();
    rdy = 1'b1; rs = '0;
    alloc_valid = 1'b0; alloc_rd = '0; alloc_tag = '0;
    commit_valid = 1'b0; commit_rd = '0; commit_tag = '0; commit_data = '0;
    ckpt_req = 1'b0; ckpt_release = 1'b0;
    restore_valid = 1'b0; restore_id = '0; flush = 1'b0;
  endtask

  task automatic settle();
    #1;
    check_outputs();
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic do_alloc(input logic [4:0] rd, input logic [3:0] tag);
    idle(); alloc_valid = 1'b1; alloc_rd = rd; alloc_tag = tag; settle(); tick();
  endtask

  task automatic do_ckpt();
    idle(); ckpt_req = 1'b1; settle(); tick();
  endtask

  task automatic do_restore(input logic [1:0] id);
    idle(); restore_valid = 1'b1; restore_id = id; settle(); tick();
  endtask

  task automatic do_commit(input logic [4:0] rd, input logic [3:0] tag, input logic [31:0] data);
    idle(); commit_valid = 1'b1; commit_rd = rd; commit_tag = tag; commit_data = data; settle(); tick();
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    model_reset();
    #12;
    rs = {5'd3, 5'd1};
    check_outputs();
    check_eq("reset_count", 64'(ckpt_count), 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Bypass of alloc, then of commit.
    idle(); alloc_valid = 1'b1; alloc_rd = 5'd5; alloc_tag = 4'd3; rs = {5'd0, 5'd5};
    settle();
    check_eq("bypass_alloc_q", 64'(q_o[3:0]), 64'd3);
    tick();
    idle(); commit_valid = 1'b1; commit_rd = 5'd5; commit_tag = 4'd3; commit_data = 32'hAB;
    rs = {5'd0, 5'd5};
    settle();
    check_eq("bypass_commit_v", 64'(v_o[31:0]), 64'hAB);
    check_eq("bypass_commit_q", 64'(q_o[3:0]), 64'd0);
    tick();

    // Stale commit leaves the newer tag.
    do_alloc(5'd7, 4'd2);
    do_alloc(5'd7, 4'd4);
    do_commit(5'd7, 4'd2, 32'd9);
    idle(); rs = {5'd0, 5'd7}; settle();
    check_eq("stale_v7", 64'(v_o[31:0]), 64'd9);
    check_eq("stale_q7", 64'(q_o[3:0]), 64'd4);

    // Checkpoint and restore.
    do_alloc(5'd1, 4'd1);
    do_ckpt();
    do_alloc(5'd1, 4'd5);
    do_ckpt();
    do_alloc(5'd2, 4'd6);
    do_restore(2'd0);
    idle(); rs = {5'd2, 5'd1}; settle();
    check_eq("restore_q1", 64'(q_o[3:0]), 64'd1);
    check_eq("restore_q2", 64'(q_o[7:4]), 64'd0);
    check_eq("restore_count", 64'(ckpt_count), 64'd0);
    check_eq("restore_id", 64'(ckpt_id), 64'd0);

    // A retired tag must not come back from a snapshot.
    do_alloc(5'd3, 4'd2);
    do_ckpt();
    do_commit(5'd3, 4'd2, 32'h33);
    do_restore(2'd0);
    idle(); rs = {5'd0, 5'd3}; settle();
    check_eq("retired_q3", 64'(q_o[3:0]), 64'd0);

    // Fill, overflow, then release+request wrap.
    for (int i = 0; i < 4; i++) do_ckpt();
    idle(); settle();
    check_eq("full_flag", 64'(ckpt_full), 64'd1);
    check_eq("full_count", 64'(ckpt_count), 64'd4);
    do_ckpt();
    idle(); settle();
    check_eq("overflow_count", 64'(ckpt_count), 64'd4);
    check_eq("overflow_id", 64'(ckpt_id), 64'd0);
    idle(); ckpt_req = 1'b1; ckpt_release = 1'b1; settle(); tick();
    idle(); settle();
    check_eq("wrap_count", 64'(ckpt_count), 64'd4);
    check_eq("wrap_id", 64'(ckpt_id), 64'd1);

    // Flush with live checkpoints and a same-cycle commit.
    idle(); flush = 1'b1; commit_valid = 1'b1; commit_rd = 5'd4; commit_tag = 4'd0;
    commit_data = 32'h11; settle(); tick();
    for (int r = 0; r < 32; r += 2) begin
      idle(); rs = {5'(r + 1), 5'(r)}; settle();
      check_eq($sformatf("flush_q%0d", r), 64'(q_o[3:0]), 64'd0);
      check_eq($sformatf("flush_q%0d", r + 1), 64'(q_o[7:4]), 64'd0);
    end
    idle(); rs = {5'd0, 5'd4}; settle();
    check_eq("flush_v4", 64'(v_o[31:0]), 64'h11);
    check_eq("flush_count", 64'(ckpt_count), 64'd0);

    // Random traffic.
    for (int n = 0; n < 600; n++) begin
      rdy           = ($urandom_range(9) != 0);
      flush         = ($urandom_range(40) == 0);
      restore_valid = ($urandom_range(7) == 0);
      restore_id    = 2'($urandom);
      ckpt_req      = ($urandom_range(3) == 0);
      ckpt_release  = ($urandom_range(3) == 0);
      alloc_valid   = 1'($urandom);
      alloc_rd      = 5'($urandom_range(7));
      alloc_tag     = 4'($urandom_range(15, 1));
      commit_valid  = 1'($urandom);
      commit_rd     = 5'($urandom_range(7));
      commit_tag    = ($urandom_range(1) == 1) ? m_q[commit_rd] : 4'($urandom);
      commit_data   = $urandom;
      for (int s = 0; s < 2; s++) begin
        case ($urandom_range(3))
          0:       rs[s*5 +: 5] = alloc_rd;
          1:       rs[s*5 +: 5] = commit_rd;
          default: rs[s*5 +: 5] = 5'($urandom_range(7));
        endcase
      end
      settle();
      tick();
    end

    // Asynchronous reset between edges.
    do_alloc(5'd6, 4'd9);
    do_ckpt();
    do_commit(5'd6, 4'd1, 32'h66);
    idle(); rs = {5'd0, 5'd6};
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_eq("async_rst_v6", 64'(v_o[31:0]), 64'd0);
    check_eq("async_rst_q6", 64'(q_o[3:0]), 64'd0);
    check_eq("async_rst_count", 64'(ckpt_count), 64'd0);
    check_outputs();
    #1;
    rst_n = 1'b1;
    tick();
    settle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
